// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - state_t   : responder FSM encoding (IDLE / WAIT / DONE)
//   - WORD_BYTES: bytes per storage word
//   - ERR_*     : internal error codes for access legality
//   - addr_check: classifies a request as legal or as one of the error kinds
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ALIGN    = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

    // Conflict wins over alignment, alignment over range; any non-NONE code
    // makes the access illegal, the precedence only picks the reported kind.
    function automatic logic [1:0] addr_check(input logic        rd,
                                              input logic        wr,
                                              input logic [31:0] addr,
                                              input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) * 34'(WORD_BYTES);
        if (rd && wr)
            return ERR_CONFLICT;
        else if (addr[1:0] != 2'b00)
            return ERR_ALIGN;
        else if ({2'b00, addr} >= limit)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline-to-data-memory bus.
//   master: MEM stage (drives mem_read, mem_write, address, write_data)
//   slave : responder (drives read_data, mem_stall, mem_done, addr_err)
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        mem_done;
    logic        addr_err;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, mem_stall, mem_done, addr_err
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, mem_stall, mem_done, addr_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: DEPTH_WORDS x 32 bits.
//   clk   : write clock
//   we    : write enable, commits wdata at index on the rising edge
//   index : word index shared by read and write
//   wdata : write data
//   rdata : asynchronous read of the word at index
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[index] <= wdata;
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of the pipeline data-memory bus
// A request accepted in IDLE completes LATENCY cycles later with a one-cycle
// mem_done pulse; mem_stall holds the pipeline for exactly LATENCY cycles.
// Illegal accesses consume the full latency, never write, and return 0 with
// addr_err set in the completion cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int CW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam bit ZERO_WAIT = (LATENCY == 0);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     addr_reg, wdata_reg;
    logic            rd_reg, wr_reg;

    logic            req, capture, live_fire, in_done, done;
    logic            fin_err, fin_wr, we;
    logic [1:0]      err_live, err_cap;
    logic [AW-1:0]   idx;
    logic [31:0]     wdata, rdata;

    assign req      = bus.mem_read | bus.mem_write;
    assign err_live = addr_check(bus.mem_read, bus.mem_write, bus.address, DEPTH_WORDS);
    assign err_cap  = addr_check(rd_reg, wr_reg, addr_reg, DEPTH_WORDS);

    // Zero-wait accesses complete straight from the live inputs; everything
    // else completes in DONE from the captured copy.
    assign live_fire = ZERO_WAIT && (state_reg == IDLE) && req && !reset;
    assign in_done   = (state_reg == DONE) && !reset;
    assign done      = live_fire | in_done;

    assign fin_err = live_fire ? (err_live != ERR_NONE) : (err_cap != ERR_NONE);
    assign fin_wr  = live_fire ? bus.mem_write : wr_reg;
    assign idx     = in_done ? addr_reg[AW+1:2] : bus.address[AW+1:2];
    assign wdata   = in_done ? wdata_reg : bus.write_data;
    assign we      = done & fin_wr & ~fin_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .index (idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign bus.mem_done  = done;
    assign bus.addr_err  = done & fin_err;
    assign bus.read_data = (done && !fin_err) ? rdata : 32'h0;
    assign bus.mem_stall = ((state_reg == IDLE) && req && !ZERO_WAIT) || (state_reg == WAIT);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && !ZERO_WAIT) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        count_next = CW'(CNT_INIT);
                    end
                end
            end
            WAIT: begin
                if (count_reg == '0)
                    state_next = DONE;
                else
                    count_next = count_reg - CW'(1);
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (capture) begin
                addr_reg  <= bus.address;
                wdata_reg <= bus.write_data;
                rd_reg    <= bus.mem_read;
                wr_reg    <= bus.mem_write;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the MEM stage of the 5-stage pipeline. It sits on the far side of the pipeline's mem_read/mem_write/address/write_data interface and replaces the zero-wait data memory with a configurable wait-state memory. It holds the pipeline through a combinational mem_stall output while an access is in service. It also checks addresses and reports an error for misaligned or out-of-range accesses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words of storage; power of two, at least 4.
LATENCY, 2, wait cycles per access; 0 gives single-cycle behaviour identical to a zero-wait memory.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
mem_read  input  1  load request from the MEM stage.
mem_write  input  1  store request from the MEM stage.
address  input  32  byte address (ALU result).
write_data  input  32  store data, already forwarded.
read_data  output  32  load data; valid only while mem_done=1.
mem_stall  output  1  freeze PC and all pipeline registers this cycle.
mem_done  output  1  one-cycle pulse marking the completion cycle of an access.
addr_err  output  1  pulses together with mem_done when the completed access was illegal.

Behaviour:
- States: IDLE, WAIT, DONE. A request is req = mem_read | mem_write.
- Acceptance:
  - A request is accepted only in IDLE.
  - On acceptance, address, write_data and op are captured into internal registers, and the capture is used thereafter.
  - The pipeline holds its inputs stable while stalled; the responder does not depend on this.
- LATENCY=0:
  - IDLE with req completes in the same cycle: mem_done=1, mem_stall=0, read_data is the combinational array read.
  - The write commits at the closing edge.
  - The FSM stays in IDLE.
- LATENCY=1: IDLE with req gives mem_stall=1 and moves to DONE.
- LATENCY>=2: IDLE with req gives mem_stall=1 and moves to WAIT with count=LATENCY-2.
- WAIT: mem_stall=1. The count decrements each cycle; when count==0 the FSM moves to DONE.
- DONE:
  - mem_stall=0 and mem_done=1.
  - read_data = array[captured word index].
  - The store commits to the array at the clock edge ending DONE.
  - The FSM returns to IDLE.
- Overall timing: request at cycle 0 completes in cycle LATENCY; mem_stall is high for exactly LATENCY cycles.
- mem_stall is combinational: (IDLE & req & LATENCY>0) | WAIT.
- Back-to-back: the cycle after DONE is IDLE, so a new request is accepted immediately. There is no dead cycle beyond the latency.
- Word index = address[2+log2(DEPTH_WORDS)-1:2].
- Illegal access, any of:
  - address[1:0] != 0;
  - address >= 4*DEPTH_WORDS;
  - mem_read & mem_write both high.
- Illegal access handling:
  - Full latency is still consumed.
  - No array write occurs.
  - read_data=0 and addr_err=1 in the completion cycle.
- read_data is 0 whenever mem_done=0.
- Reset values: FSM=IDLE, count=0, captured registers=0, mem_done=0, addr_err=0, read_data=0. mem_stall=0 unless a request is present in IDLE and LATENCY>0.
- Reset mid-access: the FSM returns to IDLE and any pending store is dropped. Array contents are not cleared and are unaffected by reset.
- Counter width: clog2(LATENCY+1), minimum 1 bit.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - WORD_BYTES=4;
  - ERR_NONE/ERR_ALIGN/ERR_RANGE/ERR_CONFLICT localparams for the internal error code.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage;
  - synchronous write on we, asynchronous read at index.
- FSM, counter and address checking stay in dmem_responder.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to 0x10 at cycle 0 -> mem_stall=1 in cycles 0-1, mem_done=1 in cycle 2, addr_err=0. A load from 0x10 issued in cycle 3 -> read_data=0xDEADBEEF in cycle 5.
- LATENCY=0: store 0x12345678 to 0x4, then load from 0x4 on the next cycle -> mem_stall never asserts, mem_done=1 each cycle, read_data=0x12345678 in the load cycle.
- Load from 0x6 (misaligned), and separately from 0x400 with DEPTH_WORDS=256 -> full latency, then mem_done=1, addr_err=1, read_data=0. No prior contents change.
- mem_read and mem_write both high, address 0x8, write_data 0xFFFFFFFF -> addr_err=1 at completion. A subsequent load of 0x8 returns its prior value.
- LATENCY=3: assert reset in cycle 1 of a store of 0xA5A5A5A5 to 0x20 -> FSM goes to IDLE, mem_stall=0 with no request present. A later load of 0x20 returns the pre-store value.
- LATENCY=1: loads from 0x0, 0x4, 0x8 issued back-to-back and held during stall -> mem_done in cycles 1, 3, 5 with the correct data each time.
